// File: rtl/s2p_shift_reg.sv
// ---------------------------------------------------------------------------------------------
// s2p_shift_reg: serial-to-parallel converter with a registered word output and a valid/ready
// handshake.
//
// Serial bits are sampled on rising clk edges where en=1 and assembled into a WIDTH-bit word.
// When the last bit of a frame is accepted, the finished word goes straight into par_q and
// par_valid rises on that same edge. Frames can follow each other with no idle edge.
//
// If a word completes while par_q still holds an unconsumed word, the new word is dropped and
// the sticky overflow flag is set.
//
// Build option (macro S2P_PARITY_EN):
//   Each frame carries one parity bit after the WIDTH data bits. The parity bit is not stored
//   in par_q. It is checked against the data, and the result appears on parity_err.
//
// Parameters:
//   WIDTH      - parallel word width in bits (>= 2)
//   MSB_FIRST  - 1: the first received bit ends up in par_q[WIDTH-1]
//                0: the first received bit ends up in par_q[0]
//   PARITY_ODD - 0: even parity, 1: odd parity (only used with S2P_PARITY_EN)
//
// Ports:
//   clk        - clock; all state changes on its rising edge
//   rst_n      - synchronous active-low reset
//   d          - serial data bit
//   en         - bit enable; d is sampled only when en=1
//   clr        - synchronous flush of the partial frame and of the overflow flag
//   par_q      - assembled parallel word (registered)
//   par_valid  - par_q holds a word that has not been consumed yet
//   par_ready  - downstream takes par_q on an edge where par_valid=1 and par_ready=1
//   bit_cnt    - number of bits received so far in the current frame
//   overflow   - sticky; set when a completed word had to be dropped
//   parity_err - parity mismatch for the word in par_q (S2P_PARITY_EN only)
// ---------------------------------------------------------------------------------------------
module s2p_shift_reg #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned PARITY_ODD = 0,
  localparam int unsigned CntW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] par_q,
  output logic             par_valid,
  input  logic             par_ready,
  output logic [CntW-1:0]  bit_cnt,
`ifdef S2P_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overflow
);

`ifdef S2P_PARITY_EN
  localparam int unsigned FrameLen = WIDTH + 1;
`else
  localparam int unsigned FrameLen = WIDTH;
`endif
  localparam logic [CntW-1:0] LastCnt = CntW'(FrameLen - 1);

  // State registers
  logic [WIDTH-1:0] r_shreg;
  logic [CntW-1:0]  r_bit_cnt;
  logic [WIDTH-1:0] r_par_q;
  logic             r_par_valid;
  logic             r_overflow;

  // Next-state values
  logic [WIDTH-1:0] w_shreg_next;
  logic [CntW-1:0]  w_bit_cnt_next;
  logic [WIDTH-1:0] w_par_q_next;
  logic             w_par_valid_next;
  logic             w_overflow_next;

  // Decoded events for this edge
  logic             w_accept;
  logic             w_last;
  logic             w_consume;
  logic             w_can_load;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_word;

  // Pick the shift direction at elaboration time.
  // Each branch then only reads the bits it actually needs.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign w_shifted = {r_shreg[WIDTH-2:0], d};
  end else begin : g_lsb_first
    assign w_shifted = {d, r_shreg[WIDTH-1:1]};
  end

  assign w_accept  = en & ~clr;
  assign w_last    = w_accept & (r_bit_cnt == LastCnt);
  assign w_consume = r_par_valid & par_ready;
  // The output slot is free if it is empty or is being consumed on this same edge.
  assign w_can_load = ~r_par_valid | par_ready;

`ifdef S2P_PARITY_EN
  logic r_parity_err;
  logic w_parity_err_next;
  logic w_parity_calc;

  // On the last edge of a frame d carries the parity bit and r_shreg already holds all the
  // data bits.
  assign w_word        = r_shreg;
  assign w_parity_calc = (^r_shreg) ^ d ^ (PARITY_ODD != 0);
`else
  // PARITY_ODD only matters when parity is built in.
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = (PARITY_ODD != 0);

  // The last data bit arrives on the completion edge, so it is taken from the shifted value.
  assign w_word = w_shifted;
`endif

  always_comb begin
    w_shreg_next     = r_shreg;
    w_bit_cnt_next   = r_bit_cnt;
    w_par_q_next     = r_par_q;
    w_par_valid_next = r_par_valid;
    w_overflow_next  = r_overflow;
`ifdef S2P_PARITY_EN
    w_parity_err_next = r_parity_err;
`endif

    // A consume always lowers par_valid, even during clr.
    // A completion on the same edge raises it again below.
    if (w_consume) begin
      w_par_valid_next = 1'b0;
    end

    if (clr) begin
      w_shreg_next    = '0;
      w_bit_cnt_next  = '0;
      w_overflow_next = 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        w_bit_cnt_next = '0;
`ifndef S2P_PARITY_EN
        w_shreg_next   = w_shifted;
`endif
        if (w_can_load) begin
          w_par_q_next     = w_word;
          w_par_valid_next = 1'b1;
`ifdef S2P_PARITY_EN
          w_parity_err_next = w_parity_calc;
`endif
        end else begin
          // The output slot is still full: drop the new word and keep the old one.
          w_overflow_next = 1'b1;
        end
      end else begin
        w_bit_cnt_next = r_bit_cnt + CntW'(1);
        w_shreg_next   = w_shifted;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_par_q     <= '0;
      r_par_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_shreg     <= w_shreg_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_par_q     <= w_par_q_next;
      r_par_valid <= w_par_valid_next;
      r_overflow  <= w_overflow_next;
    end
  end

`ifdef S2P_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_parity_err_next;
    end
  end

  assign parity_err = r_parity_err;
`endif

  assign par_q     = r_par_q;
  assign par_valid = r_par_valid;
  assign bit_cnt   = r_bit_cnt;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_s2p_shift_reg.sv
// ---------------------------------------------------------------------------------------------
// Directed self-checking bench for s2p_shift_reg.
// Two instances share the same stimulus: one with MSB_FIRST=1 and one with MSB_FIRST=0.
// ---------------------------------------------------------------------------------------------
module tb_s2p_shift_reg;

`ifdef S2P_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic       d;
  logic       en;
  logic       clr;
  logic       par_ready;
  logic [7:0] par_q_m;
  logic [7:0] par_q_l;
  logic       valid_m;
  logic       valid_l;
  logic [3:0] cnt_m;
  logic [3:0] cnt_l;
  logic       ovf_m;
  logic       ovf_l;
`ifdef S2P_PARITY_EN
  logic       perr_m;
  logic       perr_l;
`endif

  int checks = 0;
  int errors = 0;

  s2p_shift_reg #(.WIDTH(8), .MSB_FIRST(1), .PARITY_ODD(0)) dut_m (
    .clk       (clk),
    .rst_n     (rst_n),
    .d         (d),
    .en        (en),
    .clr       (clr),
    .par_q     (par_q_m),
    .par_valid (valid_m),
    .par_ready (par_ready),
    .bit_cnt   (cnt_m),
`ifdef S2P_PARITY_EN
    .parity_err(perr_m),
`endif
    .overflow  (ovf_m)
  );

  s2p_shift_reg #(.WIDTH(8), .MSB_FIRST(0), .PARITY_ODD(0)) dut_l (
    .clk       (clk),
    .rst_n     (rst_n),
    .d         (d),
    .en        (en),
    .clr       (clr),
    .par_q     (par_q_l),
    .par_valid (valid_l),
    .par_ready (par_ready),
    .bit_cnt   (cnt_l),
`ifdef S2P_PARITY_EN
    .parity_err(perr_l),
`endif
    .overflow  (ovf_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit k of a frame, in transmission order.
  // Data is sent MSB first; with parity enabled, the even-parity bit (optionally inverted) comes last.
  function automatic logic frame_bit(input logic [7:0] w, input int k, input logic flip);
    if (k < 8) return w[7-k];
    return (^w) ^ flip;
  endfunction

  // Sends the first nbits bits of a frame on consecutive edges, leaving en=1 afterwards.
  task automatic send_frame(input logic [7:0] w, input logic flip, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      d  = frame_bit(w, k, flip);
      en = 1'b1;
      tick();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    d         = 1'b0;
    en        = 1'b0;
    clr       = 1'b0;
    par_ready = 1'b0;
    tick();
    tick();
    check("rst_par_q", 32'(par_q_m), 32'h0);
    check("rst_valid", 32'(valid_m), 32'h0);
    check("rst_cnt", 32'(cnt_m), 32'h0);
    check("rst_ovf", 32'(ovf_m), 32'h0);
`ifdef S2P_PARITY_EN
    check("rst_perr", 32'(perr_m), 32'h0);
`endif

    // 1/2: frame 1,0,1,1,0,0,1,0 gives B2 on the MSB-first instance and 4D on the LSB-first one.
    rst_n     = 1'b1;
    par_ready = 1'b1;
    send_frame(8'hB2, 1'b0, FL);
    en = 1'b0;
    check("t1_par_q_msb", 32'(par_q_m), 32'hB2);
    check("t1_valid", 32'(valid_m), 32'h1);
    check("t1_cnt_wrap", 32'(cnt_m), 32'h0);
    check("t2_par_q_lsb", 32'(par_q_l), 32'h4D);
    check("t2_valid_lsb", 32'(valid_l), 32'h1);
`ifdef S2P_PARITY_EN
    check("t1_perr_ok", 32'(perr_m), 32'h0);
`endif
    tick();
    check("t1_consumed", 32'(valid_m), 32'h0);
    check("t1_par_q_hold", 32'(par_q_m), 32'hB2);

    // 3: alternate en so that every enabled edge is followed by a disabled edge carrying a wrong bit.
    for (int i = 0; i < FL - 1; i++) begin
      d  = frame_bit(8'hA5, i, 1'b0);
      en = 1'b1;
      tick();
      check("t3_cnt_en", 32'(cnt_m), 32'(i + 1));
      en = 1'b0;
      d  = ~d;
      tick();
      check("t3_cnt_hold", 32'(cnt_m), 32'(i + 1));
      check("t3_no_valid", 32'(valid_m), 32'h0);
    end
    d  = frame_bit(8'hA5, FL - 1, 1'b0);
    en = 1'b1;
    tick();
    en = 1'b0;
    check("t3_par_q", 32'(par_q_m), 32'hA5);
    check("t3_par_q_lsb", 32'(par_q_l), 32'hA5);
    check("t3_valid", 32'(valid_m), 32'h1);
    check("t3_cnt", 32'(cnt_m), 32'h0);
    tick();
    check("t3_consumed", 32'(valid_m), 32'h0);

    // 4: par_ready=0 while two frames complete, so the second one overflows.
    par_ready = 1'b0;
    send_frame(8'h11, 1'b0, FL);
    en = 1'b0;
    check("t4_first", 32'(par_q_m), 32'h11);
    check("t4_ovf_clear", 32'(ovf_m), 32'h0);
    send_frame(8'h22, 1'b0, FL);
    en = 1'b0;
    check("t4_keep_old", 32'(par_q_m), 32'h11);
    check("t4_ovf_set", 32'(ovf_m), 32'h1);
    check("t4_valid", 32'(valid_m), 32'h1);
    check("t4_cnt_wrap", 32'(cnt_m), 32'h0);
    par_ready = 1'b1;
    tick();
    par_ready = 1'b0;
    check("t4_consumed", 32'(valid_m), 32'h0);
    check("t4_ovf_sticky", 32'(ovf_m), 32'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t4_clr_ovf", 32'(ovf_m), 32'h0);
    check("t4_clr_par_q", 32'(par_q_m), 32'h11);

    // Clear in the middle of a frame: en is ignored on that edge and the partial bits are discarded.
    send_frame(8'hFF, 1'b0, 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    en  = 1'b0;
    check("clr_mid_cnt", 32'(cnt_m), 32'h0);
    send_frame(8'h0F, 1'b0, FL);
    en = 1'b0;
    check("clr_no_residue", 32'(par_q_m), 32'h0F);
    par_ready = 1'b1;
    tick();
    par_ready = 1'b0;

    // 5: back-to-back frames; the second one completes on the same edge as the consume.
    send_frame(8'h01, 1'b0, FL);
    check("t5_first", 32'(par_q_m), 32'h01);
    send_frame(8'h02, 1'b0, FL - 1);
    check("t5_hold_valid", 32'(valid_m), 32'h1);
    check("t5_hold_par_q", 32'(par_q_m), 32'h01);
    check("t5_cnt", 32'(cnt_m), 32'(FL - 1));
    par_ready = 1'b1;
    d = frame_bit(8'h02, FL - 1, 1'b0);
    tick();
    en = 1'b0;
    check("t5_valid_kept", 32'(valid_m), 32'h1);
    check("t5_par_q", 32'(par_q_m), 32'h02);
    check("t5_no_ovf", 32'(ovf_m), 32'h0);
    tick();
    check("t5_consumed", 32'(valid_m), 32'h0);

    // 6: reset in the middle of a frame, with en=1 on the reset edge.
    par_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    en    = 1'b0;
    check("t6_rst_cnt", 32'(cnt_m), 32'h0);
    check("t6_rst_par_q", 32'(par_q_m), 32'h0);
    send_frame(8'h3C, 1'b0, FL);
    en = 1'b0;
    check("t6_par_q", 32'(par_q_m), 32'h3C);
    check("t6_par_q_lsb", 32'(par_q_l), 32'h3C);
    check("t6_valid", 32'(valid_m), 32'h1);
`ifdef S2P_PARITY_EN
    par_ready = 1'b1;
    tick();
    par_ready = 1'b0;
    send_frame(8'h3C, 1'b1, FL);
    en = 1'b0;
    check("t6_perr_bad", 32'(perr_m), 32'h1);
    check("t6_perr_par_q", 32'(par_q_m), 32'h3C);
    par_ready = 1'b1;
    tick();
    par_ready = 1'b0;
    send_frame(8'h3C, 1'b0, FL);
    en = 1'b0;
    check("t6_perr_good", 32'(perr_m), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
